// File: rtl/systolic_ws_pkg.sv
// Shared definitions for the weight-stationary systolic engine.
//   state_t  : controller states
//   acc_ext  : widens a D_W-bit operand to the accumulator width (sign or zero fill)
//   LAT      : input-to-output latency in cycles for the default 4x4 array
package systolic_ws_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int DEF_ROWS = 4;
    localparam int DEF_COLS = 4;
    localparam int LAT      = DEF_ROWS + DEF_COLS;

    localparam int EXT_W = 64;

    // The operand arrives zero-padded to EXT_W; xw says how many low bits are
    // meaningful. Callers narrow the result to their own accumulator width.
    function automatic logic [EXT_W-1:0] acc_ext(input logic [EXT_W-1:0] x,
                                                 input int unsigned      xw,
                                                 input logic            isSigned);
        logic [EXT_W-1:0] mask;
        logic [EXT_W-1:0] shifted;
        mask    = (EXT_W'(1) << xw) - EXT_W'(1);
        shifted = x >> (xw - 1);
        acc_ext = x & mask;
        if (isSigned && shifted[0]) begin
            acc_ext = acc_ext | ~mask;
        end
    endfunction

endpackage

// File: rtl/systolic_ws_stream_pe.sv
// One weight-stationary processing element.
//   clk, rst  : clock, asynchronous active-high reset
//   w_load_i  : shift-load strobe; w_i is captured into the weight register
//   w_i / w_o : weight from the row above / stored weight to the row below
//   act_i/o   : activation in from the left / registered copy to the right
//   sum_i/o   : partial sum from the row above / registered sum to the row below
module pe_ws_acc
    import systolic_ws_pkg::*;
#(
    parameter int D_W    = 8,
    parameter int ACC_W  = 18,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_load_i,
    input  logic [D_W-1:0]   w_i,
    output logic [D_W-1:0]   w_o,
    input  logic [D_W-1:0]   act_i,
    output logic [D_W-1:0]   act_o,
    input  logic [ACC_W-1:0] sum_i,
    output logic [ACC_W-1:0] sum_o
);

    logic [D_W-1:0]   w_q;
    logic [D_W-1:0]   act_q;
    logic [ACC_W-1:0] sum_q;
    logic [ACC_W-1:0] actExt;
    logic [ACC_W-1:0] wExt;

    assign actExt = ACC_W'(acc_ext(EXT_W'(act_i), D_W, SIGNED));
    assign wExt   = ACC_W'(acc_ext(EXT_W'(w_q), D_W, SIGNED));

    // Both operands are widened to ACC_W before the multiply, so the product
    // and the running sum simply wrap modulo 2^ACC_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q   <= '0;
            act_q <= '0;
            sum_q <= '0;
        end else begin
            if (w_load_i) begin
                w_q <= w_i;
            end
            act_q <= act_i;
            sum_q <= sum_i + actExt * wExt;
        end
    end

    assign w_o   = w_q;
    assign act_o = act_q;
    assign sum_o = sum_q;

endmodule

// File: rtl/systolic_ws_stream.sv
// ROWS x COLS weight-stationary matrix-vector engine with streaming inputs.
//   clk, rst            : clock, asynchronous active-high reset
//   start_i, reuse_w_i  : job start (IDLE only); reuse_w_i skips weight loading
//   w_valid_i/w_data_i  : weight rows, accepted while w_ready_o (LOAD only)
//   a_valid_i/a_data_i  : activation vectors, accepted while a_ready_o (COMPUTE only)
//   a_last_i            : marks the final vector of a job
//   o_valid_o/o_data_o  : result vectors, o[c] = sum_r a[r]*W[r][c]
//   busy_o, done_o      : job in progress / one-cycle end-of-job pulse
module systolic_ws_stream
    import systolic_ws_pkg::*;
#(
    parameter int D_W    = 8,
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int ACC_W  = 18,
    parameter bit SIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  reuse_w_i,
    input  logic                  w_valid_i,
    input  logic [COLS*D_W-1:0]   w_data_i,
    output logic                  w_ready_o,
    input  logic                  a_valid_i,
    input  logic [ROWS*D_W-1:0]   a_data_i,
    input  logic                  a_last_i,
    output logic                  a_ready_o,
    output logic                  o_valid_o,
    output logic [COLS*ACC_W-1:0] o_data_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int LatCycles = ROWS + COLS;
    localparam int CntW      = $clog2(LatCycles + 1);
    localparam int BeatW     = $clog2(ROWS + 1);

    state_t           state_q, state_d;
    logic [BeatW-1:0] beatCnt_q, beatCnt_d;
    logic [CntW-1:0]  drainCnt_q, drainCnt_d;
    logic             wReady_q, aReady_q, busy_q, done_q;
    logic             wBeat, aBeat;

    logic [LatCycles-1:0]   tag_q;
    logic                   oValid_q;
    logic [COLS*ACC_W-1:0]  oData_q;

    logic [D_W-1:0]   skewOut   [ROWS];
    logic [ACC_W-1:0] deskewOut [COLS];
    logic [D_W-1:0]   actBus    [ROWS][COLS+1];
    logic [ACC_W-1:0] sumBus    [ROWS+1][COLS];
    logic [D_W-1:0]   wBus      [ROWS+1][COLS];
    logic             unusedEdge;

    assign wBeat = w_valid_i & wReady_q;
    assign aBeat = a_valid_i & aReady_q;

    // Controller next-state logic. DRAIN holds until the last injected
    // vector's result has left the output register, so done always lands
    // one cycle after the final o_valid of the job.
    always_comb begin
        state_d    = state_q;
        beatCnt_d  = beatCnt_q;
        drainCnt_d = drainCnt_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    beatCnt_d = '0;
                    state_d   = reuse_w_i ? COMPUTE : LOAD;
                end
            end
            LOAD: begin
                if (wBeat) begin
                    beatCnt_d = beatCnt_q + BeatW'(1);
                    if (beatCnt_q == BeatW'(ROWS - 1)) begin
                        state_d = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                if (aBeat && a_last_i) begin
                    drainCnt_d = '0;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (drainCnt_q == CntW'(LatCycles)) begin
                    state_d = DONE;
                end else begin
                    drainCnt_d = drainCnt_q + CntW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and status outputs decode the next state, so they change in
    // the same cycle the state register does and stay glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beatCnt_q  <= '0;
            drainCnt_q <= '0;
            wReady_q   <= 1'b0;
            aReady_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beatCnt_q  <= beatCnt_d;
            drainCnt_q <= drainCnt_d;
            wReady_q   <= (state_d == LOAD);
            aReady_q   <= (state_d == COMPUTE);
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == DONE);
        end
    end

    // Input skew: row r sees its element r cycles later than row 0, plus the
    // common capture stage. Idle cycles push zeros so gaps stay gaps.
    for (genvar r = 0; r < ROWS; r++) begin : gSkew
        logic [D_W-1:0] chain_q [0:r];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k <= r; k++) begin
                    chain_q[k] <= '0;
                end
            end else begin
                chain_q[0] <= aBeat ? a_data_i[r*D_W +: D_W] : '0;
                for (int k = 1; k <= r; k++) begin
                    chain_q[k] <= chain_q[k-1];
                end
            end
        end
        assign skewOut[r]   = chain_q[r];
        assign actBus[r][0] = skewOut[r];
    end

    for (genvar c = 0; c < COLS; c++) begin : gTopEdge
        assign sumBus[0][c] = '0;
        assign wBus[0][c]   = w_data_i[c*D_W +: D_W];
    end

    // PE grid: activations flow right, partial sums and weight loads flow down.
    for (genvar r = 0; r < ROWS; r++) begin : gRow
        for (genvar c = 0; c < COLS; c++) begin : gCol
            pe_ws_acc #(
                .D_W    (D_W),
                .ACC_W  (ACC_W),
                .SIGNED (SIGNED)
            ) uPe (
                .clk      (clk),
                .rst      (rst),
                .w_load_i (wBeat),
                .w_i      (wBus[r][c]),
                .w_o      (wBus[r+1][c]),
                .act_i    (actBus[r][c]),
                .act_o    (actBus[r][c+1]),
                .sum_i    (sumBus[r][c]),
                .sum_o    (sumBus[r+1][c])
            );
        end
    end

    // Output de-skew: column c finishes c cycles after column 0, so it is
    // delayed COLS-1-c cycles to line every column up with the last one.
    for (genvar c = 0; c < COLS; c++) begin : gDeskew
        localparam int Depth = COLS - 1 - c;
        if (Depth == 0) begin : gPass
            assign deskewOut[c] = sumBus[ROWS][c];
        end else begin : gDelay
            logic [ACC_W-1:0] chain_q [0:Depth-1];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < Depth; k++) begin
                        chain_q[k] <= '0;
                    end
                end else begin
                    chain_q[0] <= sumBus[ROWS][c];
                    for (int k = 1; k < Depth; k++) begin
                        chain_q[k] <= chain_q[k-1];
                    end
                end
            end
            assign deskewOut[c] = chain_q[Depth-1];
        end
    end

    // The tag rides alongside the data path with the same total delay, so
    // o_valid marks exactly the cycles carrying a real input vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q    <= '0;
            oValid_q <= 1'b0;
            oData_q  <= '0;
        end else begin
            tag_q    <= {tag_q[LatCycles-2:0], aBeat};
            oValid_q <= tag_q[LatCycles-1];
            for (int c = 0; c < COLS; c++) begin
                oData_q[c*ACC_W +: ACC_W] <= deskewOut[c];
            end
        end
    end

    // The right-edge activations and bottom-edge weights have no consumer.
    always_comb begin
        unusedEdge = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            unusedEdge = unusedEdge ^ (^actBus[r][COLS]);
        end
        for (int c = 0; c < COLS; c++) begin
            unusedEdge = unusedEdge ^ (^wBus[ROWS][c]);
        end
    end

    assign w_ready_o = wReady_q;
    assign a_ready_o = aReady_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign o_valid_o = oValid_q;
    assign o_data_o  = oData_q;

endmodule

// File: tb/tb_systolic_ws_stream.sv
// Directed bench for systolic_ws_stream: a signed and an unsigned instance
// share one stimulus stream; expected results are hand-computed constants.
module tb_systolic_ws_stream;
    import systolic_ws_pkg::*;

    localparam int DW = 8;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, reuseW, wValid, aValid, aLast;
    logic [C*DW-1:0] wData;
    logic [R*DW-1:0] aData;

    logic          wReady0, aReady0, oValid0, busy0, done0;
    logic [C*AW-1:0] oData0;
    logic          wReady1, aReady1, oValid1, busy1, done1;
    logic [C*AW-1:0] oData1;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cycles;
    logic sawW;
    logic expV, expD;
    logic [127:0] expData;

    always #5 clk = ~clk;

    systolic_ws_stream #(.D_W(DW), .ROWS(R), .COLS(C), .ACC_W(AW), .SIGNED(1'b1)) u0 (
        .clk(clk), .rst(rst), .start_i(start), .reuse_w_i(reuseW),
        .w_valid_i(wValid), .w_data_i(wData), .w_ready_o(wReady0),
        .a_valid_i(aValid), .a_data_i(aData), .a_last_i(aLast), .a_ready_o(aReady0),
        .o_valid_o(oValid0), .o_data_o(oData0), .busy_o(busy0), .done_o(done0)
    );

    systolic_ws_stream #(.D_W(DW), .ROWS(R), .COLS(C), .ACC_W(AW), .SIGNED(1'b0)) u1 (
        .clk(clk), .rst(rst), .start_i(start), .reuse_w_i(reuseW),
        .w_valid_i(wValid), .w_data_i(wData), .w_ready_o(wReady1),
        .a_valid_i(aValid), .a_data_i(aData), .a_last_i(aLast), .a_ready_o(aReady1),
        .o_valid_o(oValid1), .o_data_o(oData1), .busy_o(busy1), .done_o(done1)
    );

    function automatic logic [127:0] packOut(input logic [17:0] e0, input logic [17:0] e1,
                                             input logic [17:0] e2, input logic [17:0] e3);
        packOut = {56'd0, e3, e2, e1, e0};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's worth of inputs, let one rising edge pass, then
    // return the inputs to their quiet values 1 ns after that edge.
    task automatic applyStimulus(input logic st, input logic rw, input logic wv,
                                 input logic [31:0] wd, input logic av,
                                 input logic [31:0] ad, input logic al);
        start = st; reuseW = rw; wValid = wv; wData = wd;
        aValid = av; aData = ad; aLast = al;
        @(posedge clk);
        #1;
        start = 1'b0; reuseW = 1'b0; wValid = 1'b0; wData = '0;
        aValid = 1'b0; aData = '0; aLast = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic waitValid(output int cyc, output logic sawReady);
        cyc      = 0;
        sawReady = 1'b0;
        do begin
            idleCycles(1);
            cyc++;
            sawReady = sawReady | wReady0;
        end while (!oValid0 && cyc < 20);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; reuseW = 1'b0; wValid = 1'b0; wData = '0;
        aValid = 1'b0; aData = '0; aLast = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_flags_s", 128'({wReady0, aReady0, oValid0, busy0, done0}), '0);
        checkOutput("reset_data_s", 128'(oData0), '0);
        checkOutput("reset_flags_u", 128'({wReady1, aReady1, oValid1, busy1, done1}), '0);
        checkOutput("reset_data_u", 128'(oData1), '0);
        rst = 1'b0;
        idleCycles(1);

        $display("[TB] weight ordering job");
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("load_ready", 128'({wReady0, aReady0, busy0}), 128'(3'b101));
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h01010101, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h02020202, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h03030303, 1'b0, '0, 1'b0);
        checkOutput("partial_load_holds", 128'({wReady0, aReady0}), 128'(2'b10));
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h04040404, 1'b0, '0, 1'b0);
        checkOutput("compute_ready", 128'({wReady0, aReady0}), 128'(2'b01));
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h00000001, 1'b1);
        waitValid(cycles, sawW);
        checkOutput("order_latency", 128'(cycles), 128'(LAT));
        checkOutput("order_data", 128'(oData0), packOut(18'd4, 18'd4, 18'd4, 18'd4));
        idleCycles(2);

        $display("[TB] identity job");
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h01000000, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h00010000, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h00000100, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h00000001, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h04030201, 1'b1);
        waitValid(cycles, sawW);
        checkOutput("ident_latency", 128'(cycles), 128'(LAT));
        checkOutput("ident_data", 128'(oData0), packOut(18'd1, 18'd2, 18'd3, 18'd4));
        checkOutput("ident_no_done_yet", 128'(done0), '0);
        idleCycles(1);
        checkOutput("ident_done", 128'({oValid0, busy0, done0}), 128'(3'b011));
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("start_in_done_ignored", 128'({busy0, done0}), '0);

        $display("[TB] weight reuse job");
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("reuse_ready", 128'({wReady0, aReady0, busy0}), 128'(3'b011));
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h02020202, 1'b1);
        waitValid(cycles, sawW);
        checkOutput("reuse_latency", 128'(cycles), 128'(LAT));
        checkOutput("reuse_data", 128'(oData0), packOut(18'd2, 18'd2, 18'd2, 18'd2));
        checkOutput("reuse_no_wready", 128'(sawW), '0);
        idleCycles(2);

        $display("[TB] three vectors with a bubble");
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h04030201, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h08070605, 1'b0);
        idleCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h0C0B0A09, 1'b1);
        checkOutput("drain_no_aready", 128'({aReady0, busy0}), 128'(2'b01));
        for (int k = 4; k <= 13; k++) begin
            idleCycles(1);
            expV = (k == 8) || (k == 9) || (k == 11);
            expD = (k == 12);
            checkOutput($sformatf("bubble_flags_e%0d", k), 128'({oValid0, done0}), 128'({expV, expD}));
            if (expV) begin
                expData = (k == 8) ? packOut(18'd1, 18'd2, 18'd3, 18'd4) :
                          (k == 9) ? packOut(18'd5, 18'd6, 18'd7, 18'd8) :
                                     packOut(18'd9, 18'd10, 18'd11, 18'd12);
                checkOutput($sformatf("bubble_data_e%0d", k), 128'(oData0), expData);
            end
        end
        checkOutput("bubble_idle", 128'(busy0), '0);

        $display("[TB] signed and unsigned saturation-free wrap job");
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h7F7F7F7F, 1'b1);
        waitValid(cycles, sawW);
        checkOutput("sign_latency", 128'(cycles), 128'(LAT));
        checkOutput("signed_data", 128'(oData0), packOut(18'h3FE04, 18'h3FE04, 18'h3FE04, 18'h3FE04));
        checkOutput("unsigned_valid", 128'(oValid1), 128'(1));
        checkOutput("unsigned_data", 128'(oData1), packOut(18'h1FA04, 18'h1FA04, 18'h1FA04, 18'h1FA04));
        idleCycles(2);

        $display("[TB] reset in the middle of a job");
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h01010101, 1'b0);
        idleCycles(2);
        rst = 1'b1;
        #1;
        checkOutput("midrst_flags_now", 128'({wReady0, aReady0, oValid0, busy0, done0}), '0);
        checkOutput("midrst_data_now", 128'(oData0), '0);
        idleCycles(1);
        checkOutput("midrst_flags_next", 128'({wReady0, aReady0, oValid0, busy0, done0}), '0);
        rst = 1'b0;
        idleCycles(1);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h04030201, 1'b1);
        waitValid(cycles, sawW);
        checkOutput("postrst_latency", 128'(cycles), 128'(LAT));
        checkOutput("postrst_data", 128'(oData0), '0);
        idleCycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
